// File: rtl/mac_pkg.sv
// Shared types, widths and the round-robin pick function for the MAC scheduler.
package mac_pkg;

  localparam int unsigned A_W      = 25;
  localparam int unsigned B_W      = 16;
  localparam int unsigned P_W      = 48;
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned ID_MAX_W = 3;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic                clr;
    logic [P_W-1:0]      prod;
  } mac_op_t;

  // One-hot grant: first valid requester at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [ID_MAX_W-1:0] ptr,
    input int unsigned         n
  );
    logic [MAX_REQ-1:0]  grant;
    logic                found;
    logic [ID_MAX_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = ID_MAX_W'((32'(ptr) + k) % n);
      if ((k < n) && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mac_rr_scheduler_if.sv
// Request/response/readback bundle between the request sources and the MAC scheduler.
interface mac_rr_scheduler_if
  import mac_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic                   en;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_clr;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_p;
  logic [ID_W-1:0]        rd_id;
  logic [P_W-1:0]         rd_acc;
  logic                   busy;
  logic [31:0]            op_count;

  modport master (
    output en, req_valid, req_clr, req_a, req_b, rd_id,
    input  req_ready, rsp_valid, rsp_id, rsp_p, rd_acc, busy, op_count
  );

  modport slave (
    input  en, req_valid, req_clr, req_a, req_b, rd_id,
    output req_ready, rsp_valid, rsp_id, rsp_p, rd_acc, busy, op_count
  );

endinterface

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter: holds the search pointer and produces a one-hot grant.
module mac_rr_arbiter
  import mac_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    grant_id_c,
  output logic               grant_vld_c
);

  logic [ID_W-1:0] ptr;

  // Grant is purely a function of registered ptr and the current requests.
  always_comb begin
    grant_c = '0;
    if (en) begin
      grant_c = NUM_REQ'(rr_pick(MAX_REQ'(req_valid), ID_MAX_W'(ptr), NUM_REQ));
    end
  end

  // Encode the one-hot grant into an index.
  always_comb begin
    grant_id_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) grant_id_c = ID_W'(i);
    end
  end

  assign grant_vld_c = |grant_c;

  // Advance past the winner on every transfer; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_vld_c) begin
      ptr <= (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
    end
  end

endmodule

// File: rtl/mac_rr_scheduler.sv
// Shared multiplier plus per-requester accumulator bank, issued round-robin through a
// two-stage multiply/accumulate pipeline.
module mac_rr_scheduler
  import mac_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  mac_rr_scheduler_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    grant_id_c;
  logic               grant_vld_c;
  logic [A_W-1:0]     a_sel_c;
  logic [B_W-1:0]     b_sel_c;
  logic               clr_sel_c;
  logic               s1_vld;
  mac_op_t            s1_op;
  logic [P_W-1:0]     acc [NUM_REQ];
  logic [P_W-1:0]     acc_cur_c;
  logic [P_W-1:0]     acc_new_c;

  mac_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .en          (bus.en),
    .req_valid   (bus.req_valid),
    .grant_c     (grant_c),
    .grant_id_c  (grant_id_c),
    .grant_vld_c (grant_vld_c)
  );

  assign bus.req_ready = grant_c;

  // Route the granted requester's operands to the shared multiplier.
  always_comb begin
    a_sel_c   = '0;
    b_sel_c   = '0;
    clr_sel_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        a_sel_c   = bus.req_a[i*A_W +: A_W];
        b_sel_c   = bus.req_b[i*B_W +: B_W];
        clr_sel_c = bus.req_clr[i];
      end
    end
  end

  // S1: register the unsigned product and the op's id/clear flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_vld <= 1'b0;
      s1_op  <= '0;
    end else begin
      s1_vld <= grant_vld_c;
      if (grant_vld_c) begin
        s1_op.id   <= ID_MAX_W'(grant_id_c);
        s1_op.clr  <= clr_sel_c;
        s1_op.prod <= P_W'(a_sel_c) * P_W'(b_sel_c);
      end
    end
  end

  // Current accumulator of the S1 op and its updated value (wraps modulo 2^P_W).
  always_comb begin
    acc_cur_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (s1_op.id == ID_MAX_W'(i)) acc_cur_c = acc[i];
    end
    acc_new_c = s1_op.clr ? s1_op.prod : acc_cur_c + s1_op.prod;
  end

  // S2: write the accumulator, publish the response and count the completion.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) acc[i] <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_p     <= '0;
      bus.op_count  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rsp_valid <= s1_vld;
      bus.busy      <= grant_vld_c | s1_vld;
      if (s1_vld) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (s1_op.id == ID_MAX_W'(i)) acc[i] <= acc_new_c;
        end
        bus.rsp_id   <= ID_W'(s1_op.id);
        bus.rsp_p    <= acc_new_c;
        bus.op_count <= bus.op_count + 32'd1;
      end
    end
  end

  // Readback of the selected accumulator; out-of-range ids read as zero.
  always_comb begin
    bus.rd_acc = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.rd_id == ID_W'(i)) bus.rd_acc = acc[i];
    end
  end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed testbench for mac_rr_scheduler.
module tb_mac_rr_scheduler;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mac_rr_scheduler_if #(.NUM_REQ(4)) bus ();

  mac_rr_scheduler #(.NUM_REQ(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_clr   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rd_id     = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_opnd(input int id, input logic [24:0] a, input logic [15:0] b, input logic c);
    bus.req_a[id*25 +: 25] = a;
    bus.req_b[id*16 +: 16] = b;
    bus.req_clr[id]        = c;
  endtask

  // One op on a single requester; returns with its response on the outputs.
  task automatic issue_one(input int id, input logic [24:0] a, input logic [15:0] b, input logic c);
    set_opnd(id, a, b, c);
    bus.req_valid = 4'(1 << id);
    tick();
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_reset();
    logic [47:0] z;
    z = '0;
    apply_reset();
    bus.en = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    total++; if (bus.rsp_p !== z) begin bad++; $display("FAIL reset_rsp_p got=%0h exp=0", bus.rsp_p); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.op_count !== 32'd0) begin bad++; $display("FAIL reset_op_count got=%0d exp=0", bus.op_count); end
    for (int i = 0; i < 4; i++) begin
      bus.rd_id = 2'(i);
      #1;
      total++; if (bus.rd_acc !== z) begin bad++; $display("FAIL reset_acc%0d got=%0h exp=0", i, bus.rd_acc); end
    end
  endtask

  task automatic test_single();
    bus.en = 1'b1;
    set_opnd(0, 25'd3, 16'd5, 1'b0);
    bus.req_valid = 4'b0001;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_lat1 got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_lat2 got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", bus.rsp_id); end
    total++; if (bus.rsp_p !== 48'd15) begin bad++; $display("FAIL single_p got=%0d exp=15", bus.rsp_p); end
    tick();
    bus.rd_id = 2'd0;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
    total++; if (bus.rd_acc !== 48'd15) begin bad++; $display("FAIL single_rd got=%0d exp=15", bus.rd_acc); end
    issue_one(0, 25'd3, 16'd5, 1'b0);
    total++; if (bus.rsp_p !== 48'd30) begin bad++; $display("FAIL single_second got=%0d exp=30", bus.rsp_p); end
    total++; if (bus.op_count !== 32'd2) begin bad++; $display("FAIL single_count got=%0d exp=2", bus.op_count); end
  endtask

  task automatic test_round_robin();
    int prod [4];
    int j;
    logic [3:0] exp_rdy;
    apply_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_opnd(i, 25'(i + 2), 16'(10 * (i + 1)), 1'b0);
      prod[i] = (i + 2) * 10 * (i + 1);
    end
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, exp_rdy); end
      tick();
      j = k - 1;
      if (k >= 1 && j < 8) begin
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(j % 4)) begin
          bad++; $display("FAIL rr_rsp%0d got=%b/%0d exp=1/%0d", j, bus.rsp_valid, bus.rsp_id, j % 4);
        end
        total++; if (bus.rsp_p !== 48'((j / 4 + 1) * prod[j % 4])) begin
          bad++; $display("FAIL rr_p%0d got=%0d exp=%0d", j, bus.rsp_p, (j / 4 + 1) * prod[j % 4]);
        end
      end
    end
    total++; if (bus.op_count !== 32'd8) begin bad++; $display("FAIL rr_count got=%0d exp=8", bus.op_count); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      bus.rd_id = 2'(i);
      #1;
      total++; if (bus.rd_acc !== 48'(2 * prod[i])) begin bad++; $display("FAIL rr_acc%0d got=%0d exp=%0d", i, bus.rd_acc, 2 * prod[i]); end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.en = 1'b1;
    set_opnd(2, 25'h1FF_FFFF, 16'hFFFF, 1'b0);
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 128; c++) begin
      if (c == 0) begin
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_ready got=%b exp=0100", bus.req_ready); end
      end
      tick();
      if (c == 1) begin
        total++; if (bus.rsp_p !== 48'h01FF_FDFF_0001) begin bad++; $display("FAIL wrap_first got=%0h exp=1fffdff0001", bus.rsp_p); end
      end
    end
    bus.req_valid = '0;
    tick();
    tick();
    total++; if (bus.op_count !== 32'd128) begin bad++; $display("FAIL wrap_count got=%0d exp=128", bus.op_count); end
    bus.rd_id = 2'd2;
    #1;
    total++; if (bus.rd_acc !== 48'hFFFE_FF80_0080) begin bad++; $display("FAIL wrap_acc2 got=%0h exp=fffeff800080", bus.rd_acc); end
    bus.rd_id = 2'd0;
    #1;
    total++; if (bus.rd_acc !== 48'd0) begin bad++; $display("FAIL wrap_acc0 got=%0h exp=0", bus.rd_acc); end
  endtask

  task automatic test_clr();
    logic [47:0] exp_acc [4];
    exp_acc[0] = 48'd0;
    exp_acc[1] = 48'd42;
    exp_acc[2] = 48'd81;
    exp_acc[3] = 48'd0;
    bus.en = 1'b1;
    issue_one(1, 25'd6, 16'd7, 1'b0);
    total++; if (bus.rsp_p !== 48'd42 || bus.rsp_id !== 2'd1) begin bad++; $display("FAIL clr_pre got=%0d/%0d exp=42/1", bus.rsp_p, bus.rsp_id); end
    issue_one(2, 25'd9, 16'd9, 1'b1);
    total++; if (bus.rsp_p !== 48'd81 || bus.rsp_id !== 2'd2) begin bad++; $display("FAIL clr_p got=%0d/%0d exp=81/2", bus.rsp_p, bus.rsp_id); end
    for (int i = 0; i < 4; i++) begin
      bus.rd_id = 2'(i);
      #1;
      total++; if (bus.rd_acc !== exp_acc[i]) begin bad++; $display("FAIL clr_acc%0d got=%0d exp=%0d", i, bus.rd_acc, exp_acc[i]); end
    end
    set_opnd(2, 25'd0, 16'd0, 1'b0);
  endtask

  task automatic test_en_drop();
    apply_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) set_opnd(i, 25'(i + 1), 16'd1, 1'b0);
    bus.req_valid = 4'b1111;
    tick();
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 48'd1) begin bad++; $display("FAIL en_rsp0 got=%b/%0d exp=1/1", bus.rsp_valid, bus.rsp_p); end
    bus.en = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL en_ready0 got=%b exp=0000", bus.req_ready); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL en_busy0 got=%b exp=1", bus.busy); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_p !== 48'd2) begin
      bad++; $display("FAIL en_rsp1 got=%b/%0d/%0d exp=1/1/2", bus.rsp_valid, bus.rsp_id, bus.rsp_p);
    end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL en_ready1 got=%b exp=0000", bus.req_ready); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL en_busy1 got=%b exp=1", bus.busy); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL en_done got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL en_busy2 got=%b exp=0", bus.busy); end
    total++; if (bus.op_count !== 32'd2) begin bad++; $display("FAIL en_count got=%0d exp=2", bus.op_count); end
    bus.req_valid = '0;
    bus.en        = 1'b1;
  endtask

  task automatic test_rst_mid();
    apply_reset();
    bus.en = 1'b1;
    issue_one(3, 25'd4, 16'd4, 1'b0);
    set_opnd(0, 25'd2, 16'd2, 1'b0);
    set_opnd(1, 25'd3, 16'd3, 1'b0);
    bus.req_valid = 4'b0011;
    tick();
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 48'd4) begin bad++; $display("FAIL rst_pre got=%b/%0d exp=1/4", bus.rsp_valid, bus.rsp_p); end
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.op_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.op_count); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      bus.rd_id = 2'(i);
      #1;
      total++; if (bus.rd_acc !== 48'd0) begin bad++; $display("FAIL rst_acc%0d got=%0d exp=0", i, bus.rd_acc); end
    end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_dropped got=%b exp=0", bus.rsp_valid); end
    bus.req_valid = 4'b1111;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rst_ptr got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_clr();
    test_en_drop();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
